// File: rtl/dram_kv_extractor.sv
// Walks a key range, reads one 32-bit value per key through the DRAM read master,
// and pushes {key,value} pairs into the key/value FIFO, optionally dropping zero values.
module dram_kv_extractor #(
    parameter int                       ADDRESS_WIDTH  = 31,
    parameter int                       DATA_WIDTH     = 32,
    parameter int                       BLOCK_SHIFT    = 6,
    parameter logic [ADDRESS_WIDTH-1:0] DRAM_BASE_ADDR = 31'h4000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_WIDTH-1:0]      start_key,
    input  logic [DATA_WIDTH-1:0]      num_keys,
    input  logic                       filter_zero,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_WIDTH-1:0]      pairs_emitted,
    output logic                       control_fixed_location,
    output logic [ADDRESS_WIDTH-1:0]   control_read_base,
    output logic [ADDRESS_WIDTH-1:0]   control_read_length,
    output logic                       control_go,
    input  logic                       control_done,
    output logic                       user_read_buffer,
    input  logic [DATA_WIDTH-1:0]      user_buffer_output_data,
    input  logic                       user_data_available,
    output logic                       kv_fifo_write,
    output logic [2*DATA_WIDTH-1:0]    kv_fifo_writedata,
    input  logic                       kv_fifo_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_WAIT_DONE,
        S_PUSH,
        S_NEXT
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                     state_q;
    logic [DATA_WIDTH-1:0]      cur_key_q;
    logic [DATA_WIDTH-1:0]      remaining_q;
    logic                       filt_q;
    logic [DATA_WIDTH-1:0]      val_q;
    logic                       done_seen_q;
    logic                       busy_q;
    logic                       done_q;
    logic [DATA_WIDTH-1:0]      pairs_q;
    logic [ADDRESS_WIDTH-1:0]   read_base_q;
    logic [ADDRESS_WIDTH-1:0]   read_length_q;
    logic                       go_q;
    logic                       pop_q;
    logic                       kv_write_q;
    logic [2*DATA_WIDTH-1:0]    kv_data_q;

    // Block address wraps modulo 2^ADDRESS_WIDTH by construction of the widths.
    logic [ADDRESS_WIDTH-1:0]   key_ext_d;
    logic [ADDRESS_WIDTH-1:0]   read_base_d;

    assign key_ext_d   = ADDRESS_WIDTH'(cur_key_q);
    assign read_base_d = DRAM_BASE_ADDR + (key_ext_d << BLOCK_SHIFT);

    // NOTE: every register, including the datapath, is cleared by the synchronous
    // reset so all outputs read 0 on the cycle after reset is sampled low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cur_key_q     <= '0;
            remaining_q   <= '0;
            filt_q        <= 1'b0;
            val_q         <= '0;
            done_seen_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pairs_q       <= '0;
            read_base_q   <= '0;
            read_length_q <= '0;
            go_q          <= 1'b0;
            pop_q         <= 1'b0;
            kv_write_q    <= 1'b0;
            kv_data_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; pulses default low and
            // the state branches below override them for a single cycle.
            go_q   <= 1'b0;
            pop_q  <= 1'b0;
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_key_q   <= start_key;
                        remaining_q <= num_keys;
                        filt_q      <= filter_zero;
                        pairs_q     <= '0;
                        if (num_keys == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    read_base_q   <= read_base_d;
                    read_length_q <= ADDRESS_WIDTH'(4);
                    go_q          <= 1'b1;
                    state_q       <= S_WAIT_DATA;
                end

                // A completion seen together with the data word is remembered so a
                // single-cycle control_done is never lost.
                S_WAIT_DATA: begin
                    if (user_data_available) begin
                        val_q       <= user_buffer_output_data;
                        pop_q       <= 1'b1;
                        done_seen_q <= control_done;
                        state_q     <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (control_done || done_seen_q) begin
                        done_seen_q <= 1'b0;
                        if (filt_q && (val_q == '0)) begin
                            state_q <= S_NEXT;
                        end else begin
                            kv_write_q <= 1'b1;
                            kv_data_q  <= {cur_key_q, val_q};
                            state_q    <= S_PUSH;
                        end
                    end
                end

                S_PUSH: begin
                    if (!kv_fifo_waitrequest) begin
                        kv_write_q <= 1'b0;
                        pairs_q    <= pairs_q + ONE;
                        state_q    <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    cur_key_q   <= cur_key_q + ONE;
                    remaining_q <= remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign pairs_emitted          = pairs_q;
    assign control_fixed_location = 1'b0;
    assign control_read_base      = read_base_q;
    assign control_read_length    = read_length_q;
    assign control_go             = go_q;
    assign user_read_buffer       = pop_q;
    assign kv_fifo_write          = kv_write_q;
    assign kv_fifo_writedata      = kv_data_q;

endmodule

// File: tb/tb_dram_kv_extractor.sv
// Scoreboard bench for dram_kv_extractor: a DRAM read-master model, a FIFO stall driver,
// and a monitor that checks every launched read and every FIFO transfer against queues.
module tb_dram_kv_extractor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_key = '0;
    logic [31:0] num_keys = '0;
    logic        filter_zero = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] pairs_emitted;
    logic        control_fixed_location;
    logic [30:0] control_read_base;
    logic [30:0] control_read_length;
    logic        control_go;
    logic        control_done;
    logic        user_read_buffer;
    logic [31:0] user_buffer_output_data;
    logic        user_data_available;
    logic        kv_fifo_write;
    logic [63:0] kv_fifo_writedata;
    logic        kv_fifo_waitrequest;

    dram_kv_extractor dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .start_key               (start_key),
        .num_keys                (num_keys),
        .filter_zero             (filter_zero),
        .busy                    (busy),
        .done                    (done),
        .pairs_emitted           (pairs_emitted),
        .control_fixed_location  (control_fixed_location),
        .control_read_base       (control_read_base),
        .control_read_length     (control_read_length),
        .control_go              (control_go),
        .control_done            (control_done),
        .user_read_buffer        (user_read_buffer),
        .user_buffer_output_data (user_buffer_output_data),
        .user_data_available     (user_data_available),
        .kv_fifo_write           (kv_fifo_write),
        .kv_fifo_writedata       (kv_fifo_writedata),
        .kv_fifo_waitrequest     (kv_fifo_waitrequest)
    );

    always #5 clk = ~clk;

    logic [30:0] exp_addr[$];
    logic [63:0] exp_push[$];
    logic [31:0] dram_vals[$];

    int dram_lat       = 0;
    bit done_after_pop = 1'b0;
    int stall_left     = 0;

    int go_cnt = 0, pop_cnt = 0, push_cnt = 0, done_cnt = 0, stall_cnt = 0;
    bit busy_seen = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DRAM read-master model and FIFO backpressure driver, updated on the falling edge.
    initial begin
        int          cnt;
        bit          pending;
        logic [31:0] word;
        cnt = 0;
        pending = 1'b0;
        word = '0;
        user_data_available = 1'b0;
        user_buffer_output_data = '0;
        control_done = 1'b0;
        kv_fifo_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                user_data_available = 1'b0;
                control_done = 1'b0;
                pending = 1'b0;
            end else begin
                control_done = 1'b0;
                if (user_data_available && user_read_buffer) begin
                    user_data_available = 1'b0;
                    if (done_after_pop) control_done = 1'b1;
                end
                if (control_go) begin
                    pending = 1'b1;
                    cnt = dram_lat;
                    word = (dram_vals.size() > 0) ? dram_vals.pop_front() : 32'h0;
                end else if (pending) begin
                    if (cnt > 0) begin
                        cnt--;
                    end else begin
                        user_data_available = 1'b1;
                        user_buffer_output_data = word;
                        pending = 1'b0;
                        if (!done_after_pop) control_done = 1'b1;
                    end
                end
            end
            kv_fifo_waitrequest = kv_fifo_write && (stall_left > 0);
            if (kv_fifo_waitrequest) stall_left--;
        end
    end

    // Monitor: pops expected reads/pushes whenever the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (busy) busy_seen = 1'b1;
                if (done) done_cnt++;
                if (user_read_buffer) pop_cnt++;
                if (control_go) begin
                    go_cnt++;
                    if (exp_addr.size() == 0) begin
                        check("unexpected_go", 64'd1, 64'd0);
                    end else begin
                        check("read_base", control_read_base, exp_addr.pop_front());
                        check("read_length", control_read_length, 64'd4);
                        check("fixed_location", control_fixed_location, 64'd0);
                    end
                end
                if (kv_fifo_write) begin
                    if (exp_push.size() == 0) begin
                        check("unexpected_push", 64'd1, 64'd0);
                    end else if (kv_fifo_waitrequest) begin
                        stall_cnt++;
                        check("stall_data", kv_fifo_writedata, exp_push[0]);
                    end else begin
                        push_cnt++;
                        check("push_data", kv_fifo_writedata, exp_push.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] key, input logic [31:0] n, input bit filt);
        @(negedge clk);
        start = 1'b1;
        start_key = key;
        num_keys = n;
        filter_zero = filt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = budget;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                cycles = c;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic end_checks(input string tag, input int go0, input int pop0, input int push0,
                              input int done0, input int go_exp, input int push_exp,
                              input int pairs_exp);
        check({tag, "_go_count"}, go_cnt - go0, go_exp);
        check({tag, "_pop_count"}, pop_cnt - pop0, go_exp);
        check({tag, "_push_count"}, push_cnt - push0, push_exp);
        check({tag, "_done_pulses"}, done_cnt - done0, 1);
        check({tag, "_pairs_emitted"}, pairs_emitted, pairs_exp);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_addr_left"}, exp_addr.size(), 0);
        check({tag, "_push_left"}, exp_push.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pairs"}, pairs_emitted, 0);
        check({tag, "_go"}, control_go, 0);
        check({tag, "_base"}, control_read_base, 0);
        check({tag, "_length"}, control_read_length, 0);
        check({tag, "_pop"}, user_read_buffer, 0);
        check({tag, "_write"}, kv_fifo_write, 0);
        check({tag, "_wdata"}, kv_fifo_writedata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, p0, q0, d0, s0, cyc;

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;

        // Single key.
        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        dram_lat = 0; done_after_pop = 1'b0;
        dram_vals.push_back(32'hDEAD_BEEF);
        exp_addr.push_back(31'h4000_00C0);
        exp_push.push_back(64'h0000_0003_DEAD_BEEF);
        do_start(32'd3, 32'd1, 1'b0);
        wait_done(200, cyc);
        end_checks("single", g0, p0, q0, d0, 1, 1, 1);

        // Range of four keys, with a start pulse while busy that must be ignored.
        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        dram_lat = 1; done_after_pop = 1'b1;
        dram_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_addr = '{31'h4000_0280, 31'h4000_02C0, 31'h4000_0300, 31'h4000_0340};
        exp_push = '{64'h0000_000A_0000_0001, 64'h0000_000B_0000_0002,
                     64'h0000_000C_0000_0003, 64'h0000_000D_0000_0004};
        do_start(32'd10, 32'd4, 1'b0);
        repeat (3) @(negedge clk);
        do_start(32'd99, 32'd5, 1'b0);
        wait_done(400, cyc);
        end_checks("range", g0, p0, q0, d0, 4, 4, 4);

        // Zero filtering on: only the nonzero values are pushed.
        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        dram_lat = 2; done_after_pop = 1'b1;
        dram_vals = '{32'd5, 32'd0, 32'd0, 32'd7};
        exp_addr = '{31'h4000_0000, 31'h4000_0040, 31'h4000_0080, 31'h4000_00C0};
        exp_push = '{64'h0000_0000_0000_0005, 64'h0000_0003_0000_0007};
        do_start(32'd0, 32'd4, 1'b1);
        wait_done(400, cyc);
        end_checks("filter_on", g0, p0, q0, d0, 4, 2, 2);

        // Same data with filtering off: zeros are pushed too.
        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        dram_lat = 0; done_after_pop = 1'b0;
        dram_vals = '{32'd5, 32'd0, 32'd0, 32'd7};
        exp_addr = '{31'h4000_0000, 31'h4000_0040, 31'h4000_0080, 31'h4000_00C0};
        exp_push = '{64'h0000_0000_0000_0005, 64'h0000_0001_0000_0000,
                     64'h0000_0002_0000_0000, 64'h0000_0003_0000_0007};
        do_start(32'd0, 32'd4, 1'b0);
        wait_done(400, cyc);
        end_checks("filter_off", g0, p0, q0, d0, 4, 4, 4);

        // Backpressure: FIFO stalls the push for 20 cycles.
        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt; s0 = stall_cnt;
        dram_lat = 3; done_after_pop = 1'b1;
        stall_left = 20;
        dram_vals.push_back(32'h1234_5678);
        exp_addr.push_back(31'h4000_01C0);
        exp_push.push_back(64'h0000_0007_1234_5678);
        do_start(32'd7, 32'd1, 1'b0);
        wait_done(400, cyc);
        end_checks("stall", g0, p0, q0, d0, 1, 1, 1);
        check("stall_cycles", stall_cnt - s0, 20);

        // Zero-length run: immediate done, no read, busy never rises.
        g0 = go_cnt; d0 = done_cnt;
        busy_seen = 1'b0;
        do_start(32'd50, 32'd0, 1'b0);
        wait_done(10, cyc);
        check("zero_done_latency", cyc, 0);
        check("zero_go_count", go_cnt - g0, 0);
        check("zero_done_pulses", done_cnt - d0, 1);
        check("zero_busy_seen", busy_seen, 0);
        check("zero_pairs_cleared", pairs_emitted, 0);

        // Key wrap and address wrap.
        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        dram_lat = 0; done_after_pop = 1'b1;
        dram_vals = '{32'h0000_00AA, 32'h0000_00BB};
        exp_addr = '{31'h3FFF_FFC0, 31'h4000_0000};
        exp_push = '{64'hFFFF_FFFF_0000_00AA, 64'h0000_0000_0000_00BB};
        do_start(32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_done(300, cyc);
        end_checks("wrap", g0, p0, q0, d0, 2, 2, 2);

        // Reset while waiting for read data.
        g0 = go_cnt; d0 = done_cnt;
        dram_lat = 8; done_after_pop = 1'b0;
        dram_vals.push_back(32'h0000_0099);
        exp_addr.push_back(31'h4000_0140);
        do_start(32'd5, 32'd3, 1'b0);
        for (int i = 0; i < 20 && go_cnt == g0; i++) begin
            @(negedge clk);
            #2;
        end
        check("reset_go_seen", go_cnt - g0, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check_outputs_zero("midreset");
        reset = 1'b1;
        exp_addr.delete();
        exp_push.delete();
        dram_vals.delete();
        repeat (4) @(negedge clk);
        check("midreset_no_done", done_cnt - d0, 0);

        g0 = go_cnt; p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        dram_lat = 1;
        dram_vals = '{32'h0000_0055, 32'h0000_0066};
        exp_addr = '{31'h4000_0140, 31'h4000_0180};
        exp_push = '{64'h0000_0005_0000_0055, 64'h0000_0006_0000_0066};
        do_start(32'd5, 32'd2, 1'b0);
        wait_done(300, cyc);
        end_checks("after_reset", g0, p0, q0, d0, 2, 2, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
